// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window generator.
// Tap k = (dr+1)*3 + (dc+1), where dr/dc in {-1,0,1} are the row/column offsets from the centre.
// tap_slice() returns the bit offset of channel c of tap k inside the packed window bus.
package conv_pkg;

  localparam int TAP_NW   = 0;
  localparam int TAP_N    = 1;
  localparam int TAP_NE   = 2;
  localparam int TAP_W    = 3;
  localparam int TAP_C    = 4;
  localparam int TAP_E    = 5;
  localparam int TAP_SW   = 6;
  localparam int TAP_S    = 7;
  localparam int TAP_SE   = 8;
  localparam int NUM_TAPS = 9;

  // Bit offset of channel c of tap k, for ch channels of dwidth bits each.
  function automatic int tap_slice(input int k, input int c, input int ch, input int dwidth);
    return (k * ch + c) * dwidth;
  endfunction

endpackage

// File: rtl/conv_window_3x3_line_delay.sv
// line_delay: fixed DEPTH-beat delay line, a circular RAM with a single read/write pointer.
// Latency: dout is the din accepted DEPTH beats earlier (combinational read-before-write).
// Backpressure: none; the line advances only on beats where in_valid is high.
// Ports: clk, reset (async, active-high; clears the pointer only), in_valid, din[DW], dout[DW].
module line_delay #(
  parameter int DEPTH = 56,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q;

  // The slot about to be overwritten holds the oldest sample, i.e. exactly DEPTH beats old.
  assign dout = mem_q[ptr_q];

  // RAM contents are not reset; consumers mask anything read before it is filled.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_q[ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (in_valid) begin
      ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: slides a 3x3xCH window (stride 1) over a raster pixel stream.
// Latency: 1 clk from the beat that completes a window to win_valid.
// Backpressure: none; every in_valid beat is consumed; idle cycles hold state and drop win_valid/frame_done.
// Ports: clk, reset (async, active-high), in_valid, in_data[CH*DWIDTH]; win_valid, win_data[9*CH*DWIDTH],
//        win_row, win_col (window centre), frame_done (pulse with the frame's last window).
// Build option WIN_ZERO_PAD_EN: defined -> same-padding (every pixel is a centre, border taps zeroed);
//        undefined -> valid-conv (interior centres only, no masking).
module conv_window_3x3
  import conv_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CH     = 8,
  parameter int WIDTH  = 56,
  parameter int HEIGHT = 56
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [CH*DWIDTH-1:0]      in_data,
  output logic                      win_valid,
  output logic [9*CH*DWIDTH-1:0]    win_data,
  output logic [$clog2(HEIGHT)-1:0] win_row,
  output logic [$clog2(WIDTH)-1:0]  win_col,
  output logic                      frame_done
);

  localparam int PW   = CH * DWIDTH;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int LAST = NPIX + WIDTH;
  localparam int CW   = $clog2(LAST + 1);
  localparam int RW   = $clog2(HEIGHT);
  localparam int CLW  = $clog2(WIDTH);

  logic [CW-1:0]      cnt_q;
  logic [RW-1:0]      row_q;
  logic [CLW-1:0]     col_q;
  logic [PW-1:0]      w_q [NUM_TAPS];
  logic [PW-1:0]      nw  [NUM_TAPS];
  logic [PW-1:0]      pix_in, mid_in, top_in;
  logic [9*PW-1:0]    win_d;
  logic               emit_pos, emit, last_win;
  logic               win_valid_q, frame_done_q;
  logic [9*PW-1:0]    win_data_q;
  logic [RW-1:0]      win_row_q;
  logic [CLW-1:0]     win_col_q;

  // Flush beats push zeros so the bottom rows of the last windows never see input garbage.
  assign pix_in = (cnt_q >= CW'(NPIX)) ? '0 : in_data;

  // mid_in = pixel n-WIDTH, top_in = pixel n-2*WIDTH for the beat n being accepted.
  line_delay #(.DEPTH(WIDTH), .DW(PW)) u_line1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(pix_in), .dout(mid_in)
  );
  line_delay #(.DEPTH(WIDTH), .DW(PW)) u_line2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(mid_in), .dout(top_in)
  );

  // Window shifts left by one column; the new right column is {n-2W, n-W, n}.
  always_comb begin
    nw[TAP_NW] = w_q[TAP_N];
    nw[TAP_N]  = w_q[TAP_NE];
    nw[TAP_NE] = top_in;
    nw[TAP_W]  = w_q[TAP_C];
    nw[TAP_C]  = w_q[TAP_E];
    nw[TAP_E]  = mid_in;
    nw[TAP_SW] = w_q[TAP_S];
    nw[TAP_S]  = w_q[TAP_SE];
    nw[TAP_SE] = pix_in;
  end

  // row_q/col_q track the centre of the window completed by the current beat.
  assign emit_pos = (cnt_q >= CW'(WIDTH + 1));

`ifdef WIN_ZERO_PAD_EN
  assign emit     = emit_pos;
  assign last_win = (row_q == RW'(HEIGHT - 1)) && (col_q == CLW'(WIDTH - 1));

  // Zero taps off the frame edge; this also hides stale line-buffer data and row wrap-around.
  always_comb begin
    win_d = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (!((k < 3 && row_q == '0) ||
            (k >= 6 && row_q == RW'(HEIGHT - 1)) ||
            (k % 3 == 0 && col_q == '0) ||
            (k % 3 == 2 && col_q == CLW'(WIDTH - 1)))) begin
        win_d[tap_slice(k, 0, CH, DWIDTH) +: PW] = nw[k];
      end
    end
  end
`else
  assign emit     = emit_pos && (row_q != '0) && (row_q != RW'(HEIGHT - 1)) &&
                    (col_q != '0) && (col_q != CLW'(WIDTH - 1));
  assign last_win = (row_q == RW'(HEIGHT - 2)) && (col_q == CLW'(WIDTH - 2));

  always_comb begin
    win_d = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      win_d[tap_slice(k, 0, CH, DWIDTH) +: PW] = nw[k];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        w_q[k] <= '0;
      end
    end else if (in_valid) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        w_q[k] <= nw[k];
      end
      win_valid_q  <= emit;
      frame_done_q <= emit && last_win;
      if (emit) begin
        win_data_q <= win_d;
        win_row_q  <= row_q;
        win_col_q  <= col_q;
      end
      if (cnt_q == CW'(LAST)) begin
        cnt_q <= '0;
        row_q <= '0;
        col_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        if (emit_pos) begin
          if (col_q == CLW'(WIDTH - 1)) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CLW'(1);
          end
        end
      end
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3 at WIDTH=HEIGHT=4, CH=2, DWIDTH=8.
// Pixel p of a frame with base b carries ch0=b+p, ch1=b+p+0x40; flush beats carry 0xEEEE.
// Expectations follow whichever window mode (WIN_ZERO_PAD_EN) the design is built in.
module tb_conv_window_3x3;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int LASTN = W * H + W;
`ifdef WIN_ZERO_PAD_EN
  localparam bit PAD  = 1'b1;
  localparam int NWIN = 16;
`else
  localparam bit PAD  = 1'b0;
  localparam int NWIN = 4;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         win_valid;
  logic [143:0] win_data;
  logic [1:0]   win_row;
  logic [1:0]   win_col;
  logic         frame_done;

  conv_window_3x3 #(.DWIDTH(8), .CH(2), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .win_valid(win_valid), .win_data(win_data), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  int           n     = 0;
  int           dut_wins, dut_fds;
  logic [143:0] exp_data;
  logic [1:0]   exp_row, exp_col;
  logic [143:0] cap00, cap11;
  logic [7:0]   t0 [9];
  logic [7:0]   t1 [9];

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference window: taps off the frame are zero.
  function automatic logic [143:0] exp_win(input logic [7:0] base, input int r, input int c);
    logic [143:0] v;
    logic [7:0]   pv;
    int           rr, cc;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
        pv = base + 8'(rr * W + cc);
        v[k*16 +: 8]     = pv;
        v[k*16 + 8 +: 8] = pv + 8'h40;
      end
    end
    return v;
  endfunction

  function automatic logic [143:0] pack_taps(input logic [7:0] c0 [9], input logic [7:0] c1 [9]);
    logic [143:0] v;
    for (int k = 0; k < 9; k++) begin
      v[k*16 +: 8]     = c0[k];
      v[k*16 + 8 +: 8] = c1[k];
    end
    return v;
  endfunction

  // One clock: drive (or idle), then check every output against the reference.
  task automatic beat(input bit v, input logic [7:0] base);
    bit         emit, fd;
    int         i, r, c;
    logic [7:0] pv;
    @(negedge clk);
    in_valid = v;
    pv = base + 8'(n);
    in_data = (n < W * H) ? {pv + 8'h40, pv} : 16'hEEEE;
    @(posedge clk);
    #1;
    emit = 1'b0;
    fd   = 1'b0;
    if (v) begin
      if (n >= W + 1) begin
        i = n - W - 1;
        r = i / W;
        c = i % W;
        emit = PAD || (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2);
        fd = emit && (PAD ? (r == H - 1 && c == W - 1) : (r == H - 2 && c == W - 2));
        if (emit) begin
          exp_data = exp_win(base, r, c);
          exp_row  = 2'(r);
          exp_col  = 2'(c);
          if (r == 0 && c == 0) cap00 = win_data;
          if (r == 1 && c == 1) cap11 = win_data;
        end
      end
      n = (n == LASTN) ? 0 : n + 1;
    end
    if (win_valid === 1'b1) dut_wins++;
    if (frame_done === 1'b1) dut_fds++;
    chk("win_valid", 144'(win_valid), 144'(emit));
    chk("frame_done", 144'(frame_done), 144'(fd));
    chk("win_data", win_data, exp_data);
    chk("win_row", 144'(win_row), 144'(exp_row));
    chk("win_col", 144'(win_col), 144'(exp_col));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 144'(win_valid), 144'(0));
    chk({tag, "_done"}, 144'(frame_done), 144'(0));
    chk({tag, "_data"}, win_data, 144'(0));
    chk({tag, "_row"}, 144'(win_row), 144'(0));
    chk({tag, "_col"}, 144'(win_col), 144'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    n        = 0;
    exp_data = '0;
    exp_row  = '0;
    exp_col  = '0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    cap00    = '0;
    cap11    = '0;

    // Reset held with traffic present: outputs stay cleared.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");
    end
    release_reset();

    // One continuous frame.
    dut_wins = 0;
    dut_fds  = 0;
    for (int p = 0; p <= LASTN; p++) beat(1'b1, 8'h00);
    chk("frame1_windows", 144'(dut_wins), 144'(NWIN));
    chk("frame1_done_cnt", 144'(dut_fds), 144'(1));
    t0 = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A};
    t1 = '{8'h40, 8'h41, 8'h42, 8'h44, 8'h45, 8'h46, 8'h48, 8'h49, 8'h4A};
    chk("centre11_taps", cap11, pack_taps(t0, t1));
`ifdef WIN_ZERO_PAD_EN
    t0 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04, 8'h05};
    t1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h41, 8'h00, 8'h44, 8'h45};
    chk("centre00_taps", cap00, pack_taps(t0, t1));
`endif

    // Same frame with random idle gaps between beats.
    dut_wins = 0;
    dut_fds  = 0;
    beat(1'b0, 8'h00);
    for (int p = 0; p <= LASTN; p++) begin
      repeat ($urandom_range(0, 2)) beat(1'b0, 8'h00);
      beat(1'b1, 8'h00);
    end
    chk("gap_windows", 144'(dut_wins), 144'(NWIN));
    chk("gap_done_cnt", 144'(dut_fds), 144'(1));

    // Two back-to-back frames; the second one offset by 0x80.
    dut_wins = 0;
    dut_fds  = 0;
    for (int p = 0; p <= LASTN; p++) beat(1'b1, 8'h00);
    for (int p = 0; p <= LASTN; p++) beat(1'b1, 8'h80);
    chk("b2b_windows", 144'(dut_wins), 144'(2 * NWIN));
    chk("b2b_done_cnt", 144'(dut_fds), 144'(2));
    t0 = '{8'h80, 8'h81, 8'h82, 8'h84, 8'h85, 8'h86, 8'h88, 8'h89, 8'h8A};
    t1 = '{8'hC0, 8'hC1, 8'hC2, 8'hC4, 8'hC5, 8'hC6, 8'hC8, 8'hC9, 8'hCA};
    chk("f2_centre11_taps", cap11, pack_taps(t0, t1));
`ifdef WIN_ZERO_PAD_EN
    t0 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h81, 8'h00, 8'h84, 8'h85};
    t1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hC1, 8'h00, 8'hC4, 8'hC5};
    chk("f2_centre00_taps", cap00, pack_taps(t0, t1));
`endif

    // Reset after 9 beats of a partial frame, then a clean frame.
    for (int p = 0; p < 9; p++) beat(1'b1, 8'h30);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midframe_reset");
    release_reset();
    dut_wins = 0;
    dut_fds  = 0;
    for (int p = 0; p <= LASTN; p++) beat(1'b1, 8'h10);
    chk("post_reset_windows", 144'(dut_wins), 144'(NWIN));
    chk("post_reset_done_cnt", 144'(dut_fds), 144'(1));
    t0 = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16, 8'h18, 8'h19, 8'h1A};
    t1 = '{8'h50, 8'h51, 8'h52, 8'h54, 8'h55, 8'h56, 8'h58, 8'h59, 8'h5A};
    chk("post_reset_centre11", cap11, pack_taps(t0, t1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
